pellet_map_ctrl: RTL and testbench

Sequencer and arbiter for the Pac-Man pellet map. Owns a single-port 1-bit pellet RAM of 36×28 tiles. It loads the RAM from a layout ROM at level start, then shares the single RAM port between two requesters: the VGA pellet-draw lookup and Pac-Man's eat (read-modify-write) request. It also tracks pellets remaining and flags level clear for the game FSM.

---
 rtl/pellet_map_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pellet_map_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_map_ctrl.sv
// Pellet map sequencer: loads the 36x28 pellet RAM from the layout ROM, then arbitrates its single port.
// Latency: video lookup answers 1 cycle after request; eat acks 1 cycle after grant plus any video stall in EAT_WR.
// Backpressure: video has fixed priority and is never stalled; eat_req is held by the requester until eat_ack.
module pellet_map_ctrl #(
  parameter int ROWS = 36,
  parameter int COLS = 28,
  parameter int AW   = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          level_start,
  output logic [AW-1:0] layout_addr,
  input  logic          layout_bit,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_wdata,
  input  logic          mem_rdata,
  input  logic          vid_req,
  input  logic [5:0]    vid_row,
  input  logic [4:0]    vid_col,
  output logic          vid_valid,
  output logic          vid_pellet,
  input  logic          eat_req,
  input  logic [5:0]    eat_row,
  input  logic [4:0]    eat_col,
  output logic          eat_ack,
  output logic          eat_hit,
  output logic          busy,
  output logic [9:0]    pellets_left,
  output logic          level_clear
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_SERVE   = 3'd2;
  localparam logic [2:0] S_EAT_CHK = 3'd3;
  localparam logic [2:0] S_EAT_WR  = 3'd4;

  // idx reaches this value in the cycle that writes the last tile (idx-1 = 1007)
  localparam logic [AW-1:0] FILL_LAST = AW'(ROWS * COLS);
  localparam logic [5:0]    ROWS_W    = 6'(ROWS);
  localparam logic [4:0]    COLS_W    = 5'(COLS);

  // row*28 + col built from shifts so no multiplier is needed
  function automatic logic [AW-1:0] tile_addr(input logic [5:0] r, input logic [4:0] c);
    return AW'({r, 4'b0000}) + AW'({r, 3'b000}) + AW'({r, 2'b00}) + AW'(c);
  endfunction

  logic [2:0]    state, state_n;
  logic [AW-1:0] idx;
  logic          vid_rd_q;    // last cycle's video request actually read the RAM
  logic          eat_oor_q;   // eat in EAT_CHK was out of range, answer without the RAM
  logic          idle_ack_q;  // eat acknowledged while the map is not loaded
  logic          fill_inc;
  logic          eat_dec;
  logic          eat_ack_c;
  logic          eat_hit_c;

  logic [AW-1:0] vid_addr, eat_addr;
  logic          vid_in_range, eat_in_range, serve_grp, vid_ram_rd;

  assign vid_addr     = tile_addr(vid_row, vid_col);
  assign eat_addr     = tile_addr(eat_row, eat_col);
  assign vid_in_range = (vid_row < ROWS_W) && (vid_col < COLS_W);
  assign eat_in_range = (eat_row < ROWS_W) && (eat_col < COLS_W);
  assign serve_grp    = (state == S_SERVE) || (state == S_EAT_CHK) || (state == S_EAT_WR);
  // video owns the port whenever it asks; eat writes only happen with vid_req low
  assign vid_ram_rd   = serve_grp && vid_req && vid_in_range;

  assign busy       = (state == S_FILL);
  assign vid_pellet = vid_rd_q & mem_rdata;
  assign eat_ack    = eat_ack_c;
  assign eat_hit    = eat_hit_c;

  // Next-state, RAM/ROM port muxing and eat completion
  always_comb begin
    state_n     = state;
    layout_addr = '0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = 1'b0;
    eat_ack_c   = idle_ack_q;
    eat_hit_c   = 1'b0;
    fill_inc    = 1'b0;
    eat_dec     = 1'b0;
    if (vid_ram_rd) mem_addr = vid_addr;
    case (state)
      S_IDLE: ;
      S_FILL: begin
        layout_addr = idx;
        if (idx != '0) begin
          mem_addr  = idx - AW'(1);
          mem_we    = 1'b1;
          mem_wdata = layout_bit;
          fill_inc  = layout_bit;
        end
        if (idx == FILL_LAST) state_n = S_SERVE;
      end
      S_SERVE: begin
        if (eat_req) begin
          if (!eat_in_range) begin
            state_n = S_EAT_CHK;
          end else if (!vid_req) begin
            mem_addr = eat_addr;
            state_n  = S_EAT_CHK;
          end
        end
      end
      S_EAT_CHK: begin
        if (eat_oor_q || !mem_rdata) begin
          eat_ack_c = 1'b1;
          state_n   = S_SERVE;
        end else if (!vid_req) begin
          mem_addr  = eat_addr;
          mem_we    = 1'b1;
          eat_ack_c = 1'b1;
          eat_hit_c = 1'b1;
          eat_dec   = 1'b1;
          state_n   = S_SERVE;
        end else begin
          state_n = S_EAT_WR;
        end
      end
      S_EAT_WR: begin
        // pellet already confirmed present; nobody else writes, so no re-read
        if (!vid_req) begin
          mem_addr  = eat_addr;
          mem_we    = 1'b1;
          eat_ack_c = 1'b1;
          eat_hit_c = 1'b1;
          eat_dec   = 1'b1;
          state_n   = S_SERVE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // level_start aborts whatever is in flight: no ack, no write
    if (level_start) begin
      state_n   = S_FILL;
      mem_we    = 1'b0;
      mem_wdata = 1'b0;
      eat_ack_c = 1'b0;
      eat_hit_c = 1'b0;
      fill_inc  = 1'b0;
      eat_dec   = 1'b0;
    end
  end

  // State, fill counter, pellet bookkeeping and response strobes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      pellets_left <= '0;
      level_clear  <= 1'b0;
      vid_valid    <= 1'b0;
      vid_rd_q     <= 1'b0;
      eat_oor_q    <= 1'b0;
      idle_ack_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_FILL && state_n == S_FILL && !level_start)
        idx <= idx + AW'(1);
      else
        idx <= '0;
      if (level_start)
        pellets_left <= '0;
      else if (fill_inc)
        pellets_left <= pellets_left + 10'd1;
      else if (eat_dec && pellets_left != '0)
        pellets_left <= pellets_left - 10'd1;
      if (level_start)
        level_clear <= 1'b0;
      else if (serve_grp && pellets_left == '0)
        level_clear <= 1'b1;
      vid_valid  <= vid_req;
      vid_rd_q   <= vid_ram_rd;
      eat_oor_q  <= (state == S_SERVE) && eat_req && !eat_in_range;
      idle_ack_q <= (state == S_IDLE) && eat_req && !idle_ack_q && !level_start;
    end
  end

endmodule

// File: tb/tb_pellet_map_ctrl.sv
// Testbench for pellet_map_ctrl: ROM/RAM models plus a queue scoreboard for video and eat responses.
module tb_pellet_map_ctrl;
  localparam int AW = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          level_start = 1'b0;
  logic [AW-1:0] layout_addr;
  logic          layout_bit = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_wdata;
  logic          mem_rdata = 1'b0;
  logic          vid_req = 1'b0;
  logic [5:0]    vid_row = '0;
  logic [4:0]    vid_col = '0;
  logic          vid_valid, vid_pellet;
  logic          eat_req = 1'b0;
  logic [5:0]    eat_row = '0;
  logic [4:0]    eat_col = '0;
  logic          eat_ack, eat_hit, busy, level_clear;
  logic [9:0]    pellets_left;

  pellet_map_ctrl #(.ROWS(36), .COLS(28), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .level_start(level_start),
    .layout_addr(layout_addr), .layout_bit(layout_bit),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
    .vid_valid(vid_valid), .vid_pellet(vid_pellet),
    .eat_req(eat_req), .eat_row(eat_row), .eat_col(eat_col),
    .eat_ack(eat_ack), .eat_hit(eat_hit),
    .busy(busy), .pellets_left(pellets_left), .level_clear(level_clear)
  );

  always #5 Clk = ~Clk;

  logic ram [0:1023];
  logic rom [0:1023];
  int   cyc = 0;
  int   we_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   vid_seen = 0;
  int   ack_cnt = 0;
  int   ack_cyc = 0;
  bit   vid_q[$];
  bit   eat_q[$];
  bit   mon_e;

  // synchronous ROM and single-port RAM, 1-cycle read latency
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata  <= ram[mem_addr];
    layout_bit <= rom[layout_addr];
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a response
  always @(negedge Clk) begin
    if (vid_valid === 1'b1) begin
      vid_seen++;
      if (vid_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vid_unexpected: vid_valid with no pending request (cycle %0d)", cyc);
      end else begin
        mon_e = vid_q.pop_front();
        check("vid_pellet", {31'b0, vid_pellet}, {31'b0, mon_e});
      end
    end
    if (eat_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (eat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL eat_unexpected: eat_ack with no pending eat (cycle %0d)", cyc);
      end else begin
        mon_e = eat_q.pop_front();
        check("eat_hit", {31'b0, eat_hit}, {31'b0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(output int t);
    level_start = 1'b1;
    t = cyc;
    tick();
    level_start = 1'b0;
  endtask

  task automatic wait_fill();
    int k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL fill_timeout: busy still %0d after %0d cycles", busy, k);
    end
  endtask

  task automatic wait_ack(input int n0);
    int k = 0;
    while (ack_cnt == n0 && k < 3000) begin tick(); k++; end
    if (ack_cnt == n0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: ack count %0d, expected more than %0d", ack_cnt, n0);
    end
  endtask

  task automatic do_eat(input logic [5:0] r, input logic [4:0] c, input bit hit, input int lat);
    int g, n0;
    eat_q.push_back(hit);
    eat_row = r; eat_col = c; eat_req = 1'b1;
    g = cyc; n0 = ack_cnt;
    wait_ack(n0);
    eat_req = 1'b0;
    check("eat_latency", ack_cyc - g, lat);
  endtask

  task automatic vid_burst(input logic [5:0] r, input logic [4:0] c, input bit exp);
    vid_row = r; vid_col = c; vid_req = 1'b1;
    vid_q.push_back(exp);
    tick();
  endtask

  initial begin
    int t, g, n0, v0, w0, mism;
    for (int a = 0; a < 1024; a++) begin
      ram[a] = 1'b0;
      rom[a] = ((a < 966) && (a % 4 == 1)) || (a == 146) || (a == 1006);
    end

    // reset state
    tick(); tick();
    check("rst_vid_valid", {31'b0, vid_valid}, 0);
    check("rst_eat_ack", {31'b0, eat_ack}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_pellets", {22'b0, pellets_left}, 0);
    check("rst_level_clear", {31'b0, level_clear}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_addrs", {12'b0, layout_addr, mem_addr}, 0);
    Reset = 1'b0;
    tick();

    // IDLE: video answers 0, eat acks with no hit, RAM untouched
    vid_burst(6'd0, 5'd1, 1'b0);
    vid_req = 1'b0;
    do_eat(6'd1, 5'd1, 1'b0, 1);
    check("idle_no_write", we_cnt, 0);

    // load the 244-pellet layout, with one video lookup during FILL
    pulse_start(t);
    check("fill_busy_first", {31'b0, busy}, 1);
    check("fill_layout_addr0", {22'b0, layout_addr}, 0);
    vid_burst(6'd0, 5'd1, 1'b0);
    vid_req = 1'b0;
    wait_fill();
    check("fill_duration", cyc - t, 1010);
    check("fill_pellets", {22'b0, pellets_left}, 244);
    check("fill_level_clear", {31'b0, level_clear}, 0);
    check("fill_writes", we_cnt, 1008);
    mism = 0;
    for (int a = 0; a < 1008; a++) if (ram[a] !== rom[a]) mism++;
    check("ram_vs_rom", mism, 0);

    // back-to-back video lookups in SERVE
    v0 = vid_seen;
    vid_burst(6'd0, 5'd0, 1'b0);
    vid_burst(6'd0, 5'd1, 1'b1);
    vid_burst(6'd35, 5'd26, 1'b1);
    vid_burst(6'd35, 5'd27, 1'b0);
    vid_burst(6'd2, 5'd3, 1'b0);
    vid_burst(6'd10, 5'd5, 1'b1);
    vid_req = 1'b0;
    tick();
    check("vid_b2b_count", vid_seen - v0, 6);

    // eat (1,1) twice
    do_eat(6'd1, 5'd1, 1'b1, 1);
    check("eat1_pellets", {22'b0, pellets_left}, 243);
    tick();
    do_eat(6'd1, 5'd1, 1'b0, 1);
    check("eat1_again_pellets", {22'b0, pellets_left}, 243);
    tick();

    // eat (5,6) stalled in EAT_WR by 20 cycles of video
    eat_q.push_back(1'b1);
    eat_row = 6'd5; eat_col = 5'd6; eat_req = 1'b1;
    g = cyc; n0 = ack_cnt; v0 = vid_seen;
    tick();
    for (int i = 0; i < 20; i++) vid_burst(6'd0, 5'd1, 1'b1);
    vid_req = 1'b0;
    check("stall_no_ack", ack_cnt, n0);
    wait_ack(n0);
    eat_req = 1'b0;
    check("stall_latency", ack_cyc - g, 21);
    check("stall_vid_count", vid_seen - v0, 20);
    check("stall_pellets", {22'b0, pellets_left}, 242);
    tick();

    // out-of-range eat and video
    w0 = we_cnt;
    do_eat(6'd36, 5'd0, 1'b0, 1);
    vid_burst(6'd0, 5'd28, 1'b0);
    vid_req = 1'b0;
    tick();
    check("oor_no_write", we_cnt - w0, 0);
    check("oor_pellets", {22'b0, pellets_left}, 242);

    // level_start while an eat waits in EAT_WR
    eat_q.push_back(1'b1);
    eat_row = 6'd0; eat_col = 5'd1; eat_req = 1'b1;
    n0 = ack_cnt;
    tick();
    vid_burst(6'd0, 5'd0, 1'b0);
    vid_burst(6'd0, 5'd0, 1'b0);
    vid_row = 6'd0; vid_col = 5'd0; vid_req = 1'b1;
    vid_q.push_back(1'b0);
    pulse_start(t);
    vid_req = 1'b0;
    check("abort_busy", {31'b0, busy}, 1);
    check("abort_layout_addr0", {22'b0, layout_addr}, 0);
    check("abort_no_we", {31'b0, mem_we}, 0);
    tick();
    check("abort_first_wr_addr", {21'b0, mem_we, mem_addr}, 32'h400);
    wait_fill();
    check("abort_no_ack_in_fill", ack_cnt, n0);
    wait_ack(n0);
    eat_req = 1'b0;
    check("abort_held_eat_cycle", ack_cyc - t, 1011);
    check("abort_pellets", {22'b0, pellets_left}, 243);
    tick();

    // two-pellet layout, eat both, level_clear
    for (int a = 0; a < 1024; a++) rom[a] = (a == 29) || (a == 146);
    pulse_start(t);
    wait_fill();
    check("two_pellets", {22'b0, pellets_left}, 2);
    check("two_level_clear0", {31'b0, level_clear}, 0);
    do_eat(6'd1, 5'd1, 1'b1, 1);
    check("two_after_first", {22'b0, pellets_left}, 1);
    tick();
    do_eat(6'd5, 5'd6, 1'b1, 1);
    check("two_after_second", {22'b0, pellets_left}, 0);
    check("clear_not_yet", {31'b0, level_clear}, 0);
    tick();
    check("clear_set", {31'b0, level_clear}, 1);
    pulse_start(t);
    check("clear_dropped", {31'b0, level_clear}, 0);
    check("clear_busy", {31'b0, busy}, 1);

    tick();
    check("vid_queue_drained", vid_q.size(), 0);
    check("eat_queue_drained", eat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
